// File: rtl/debounce_edge.sv
// Debounces a slow single-bit level into a stable level,
// one-cycle rise/fall pulses and a saturating rising-edge count.
module debounce_edge #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_i,
  input  logic             clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [SW-1:0]          r_stab;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_sync;
  state_t                 w_nstate;
  logic [SW-1:0]          w_nstab;
  logic                   w_rise;
  logic                   w_fall;
  logic [CNT_W-1:0]       w_cnt_base;
  logic [CNT_W-1:0]       w_cnt_next;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nstab  = r_stab;
    w_rise   = 1'b0;
    w_fall   = 1'b0;
    unique case (r_state)
      LOW: begin
        if (w_sync) begin
          if (STABLE_CYCLES == 1) begin
            w_nstate = HIGH;
            w_rise   = 1'b1;
          end else begin
            w_nstate = WAIT_HIGH;
            w_nstab  = SW'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (!w_sync) begin
          w_nstate = LOW;
          w_nstab  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_nstate = HIGH;
          w_nstab  = '0;
          w_rise   = 1'b1;
        end else begin
          w_nstab  = r_stab + SW'(1);
        end
      end
      HIGH: begin
        if (!w_sync) begin
          if (STABLE_CYCLES == 1) begin
            w_nstate = LOW;
            w_fall   = 1'b1;
          end else begin
            w_nstate = WAIT_LOW;
            w_nstab  = SW'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (w_sync) begin
          w_nstate = HIGH;
          w_nstab  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_nstate = LOW;
          w_nstab  = '0;
          w_fall   = 1'b1;
        end else begin
          w_nstab  = r_stab + SW'(1);
        end
      end
      default: begin
        w_nstate = LOW;
        w_nstab  = '0;
      end
    endcase
  end

  // clear first, then count, so a clear coinciding with a rise yields 1
  always_comb begin
    w_cnt_base = clr_i ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_rise && (w_cnt_base != {CNT_W{1'b1}})) begin
      w_cnt_next = w_cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOW;
      r_stab  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_stab  <= w_nstab;
      r_level <= (w_nstate == HIGH) || (w_nstate == WAIT_LOW);
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_busy  <= (w_nstate == WAIT_HIGH) || (w_nstate == WAIT_LOW);
      r_cnt   <= w_cnt_next;
    end
  end

  assign level_o    = r_level;
  assign rise_o     = r_rise;
  assign fall_o     = r_fall;
  assign busy_o     = r_busy;
  assign edge_cnt_o = r_cnt;

endmodule
